// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the E stage: a single-cycle registered
// multiply or a 32-step restoring divide, stalling the pipeline until {HI,LO} is ready.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [1:0]           op_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    input  logic                 flush_i,
    output logic                 stall_o,
    output logic                 result_valid_o,
    output logic [2*WIDTH-1:0]   hilo_o
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t               state;
    logic [4:0]           count;
    logic                 isUnsigned;
    logic                 signA;
    logic                 signB;
    logic [WIDTH-1:0]     aReg;
    logic [WIDTH-1:0]     bReg;
    logic [WIDTH-1:0]     divisor;
    logic [2*WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0]   remNext;

    function automatic logic [WIDTH-1:0] negIf(input logic doNeg, input logic [WIDTH-1:0] x);
        return doNeg ? -x : x;
    endfunction

    // Operands are extended to 2*WIDTH first so one modular multiply serves both signednesses.
    function automatic logic [2*WIDTH-1:0] mulProduct(input logic uns,
                                                      input logic [WIDTH-1:0] x,
                                                      input logic [WIDTH-1:0] y);
        logic [2*WIDTH-1:0] xe;
        logic [2*WIDTH-1:0] ye;
        xe = {{WIDTH{~uns & x[WIDTH-1]}}, x};
        ye = {{WIDTH{~uns & y[WIDTH-1]}}, y};
        return xe * ye;
    endfunction

    // The top WIDTH+1 bits include the bit shifted out of the remainder half, so the
    // trial subtraction never loses the carry when the divisor is large.
    function automatic logic [2*WIDTH-1:0] divStep(input logic [2*WIDTH-1:0] r,
                                                   input logic [WIDTH-1:0] d);
        logic [WIDTH:0] top;
        logic [WIDTH:0] diff;
        top  = r[2*WIDTH-1:WIDTH-1];
        diff = top - {1'b0, d};
        if (!diff[WIDTH])
            return {diff[WIDTH-1:0], r[WIDTH-2:0], 1'b1};
        else
            return {top[WIDTH-1:0], r[WIDTH-2:0], 1'b0};
    endfunction

    function automatic logic [2*WIDTH-1:0] divFinal(input logic [2*WIDTH-1:0] r,
                                                    input logic sA,
                                                    input logic sB,
                                                    input logic zeroDiv,
                                                    input logic [WIDTH-1:0] aRaw);
        if (zeroDiv)
            return {aRaw, {WIDTH{1'b1}}};
        else
            return {negIf(sA, r[2*WIDTH-1:WIDTH]), negIf(sA ^ sB, r[WIDTH-1:0])};
    endfunction

    always_comb begin
        remNext = divStep(rem, divisor);
        stall_o = ~flush_i & (((state == IDLE) & start_i) | (state == MUL) | (state == DIV));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            count          <= 5'd0;
            result_valid_o <= 1'b0;
            hilo_o         <= '0;
        end else begin
            result_valid_o <= 1'b0;
            if (flush_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            isUnsigned <= op_i[0];
                            aReg       <= a_i;
                            bReg       <= b_i;
                            signA      <= ~op_i[0] & a_i[WIDTH-1];
                            signB      <= ~op_i[0] & b_i[WIDTH-1];
                            divisor    <= negIf(~op_i[0] & b_i[WIDTH-1], b_i);
                            rem        <= {{WIDTH{1'b0}}, negIf(~op_i[0] & a_i[WIDTH-1], a_i)};
                            count      <= 5'd0;
                            state      <= op_i[1] ? DIV : MUL;
                        end
                    end
                    MUL: begin
                        hilo_o         <= mulProduct(isUnsigned, aReg, bReg);
                        result_valid_o <= 1'b1;
                        state          <= DONE;
                    end
                    DIV: begin
                        rem   <= remNext;
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            hilo_o         <= divFinal(remNext, signA, signB, divisor == '0, aReg);
                            result_valid_o <= 1'b1;
                            state          <= DONE;
                        end
                    end
                    default: begin
                        // start_i here still belongs to the retiring instruction.
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Execute-stage sequencer for the HI/LO multiply/divide unit. It accepts MULT/MULTU/DIV/DIVU operations decoded upstream (the instructions that assert hilo write enable), runs a registered multiply or a 32-iteration restoring divide, and stalls the pipeline until the 64-bit {HI,LO} result is ready. It also drops the operation cleanly on an exception flush. It sits beside the ALU in E and feeds the HI/LO register write port.

## Interface
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  a mul/div instruction is valid in E; held high while stalled.
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i in IDLE.
- a_i  in  WIDTH  rs operand (dividend / multiplicand).
- b_i  in  WIDTH  rt operand (divisor / multiplier).
- flush_i  in  1  exception/ERET flush of E; cancels any operation.
- stall_o  out  1  hold F/D/E; combinational.
- result_valid_o  out  1  one-cycle pulse: hilo_o valid, write HI/LO this cycle.
- hilo_o  out  2*WIDTH  {HI, LO}; holds last result until the next one completes.

## Operation
- FSM states: IDLE, MUL, DIV, DONE. Reset state is IDLE.
- IDLE, start_i=1 and flush_i=0:
  - Latch op, a_i and b_i.
  - For DIV, latch |a|, |b| and the sign bits.
  - Go to MUL for op[1]=0, DIV for op[1]=1.
- IDLE otherwise: stay in IDLE.
- MUL: register product into hilo_o, then go to DONE.
  - MULT uses a signed 2*WIDTH product; MULTU uses unsigned.
- DIV: one restoring step per cycle on a 2*WIDTH partial remainder.
  - A 5-bit counter runs 0..31; at count 31 go to DONE.
  - Sign fix in the final step, DIV only: quotient negated if sign(a)≠sign(b); remainder takes the sign of a.
  - DIVU has no sign fix.
- Divisor zero, DIV or DIVU: hilo_o = {a, 32'hFFFF_FFFF}. No exception is raised.
- DONE: result_valid_o=1 and stall_o=0, so the pipeline advances. Go to IDLE next cycle.
- start_i is ignored in DONE because it belongs to the instruction that is retiring.
- stall_o = ~flush_i & ((IDLE & start_i) | MUL | DIV).
- flush_i=1 in any state:
  - Next state is IDLE.
  - No result_valid_o pulse for the cancelled op.
  - hilo_o is unchanged from its pre-op value, so the result register is written only on the MUL→DONE and DIV→DONE transitions.
  - A flush in DONE still leaves result_valid_o high that cycle. Gating the HI/LO write with flush is the writeback's responsibility.
- Reset values: stall_o=0 (when start_i=0), result_valid_o=0, hilo_o=0, counter=0.

## Timing
- Cycle numbering: cycle 0 is the first cycle start_i is high in IDLE.
- MULT/MULTU:
  - stall_o high in cycles 0 and 1.
  - result_valid_o high in cycle 2.
  - Instruction leaves E at the end of cycle 2.
- DIV/DIVU:
  - stall_o high in cycles 0..32 (33 cycles).
  - result_valid_o high in cycle 33.
- Back-to-back ops: the next instruction's start_i is seen in IDLE at cycle 3 (mul) or cycle 34 (div). There are no dead cycles beyond that.
- rst is checked before flush_i and start_i. A reset mid-DIV returns to IDLE next cycle with hilo_o=0.

## Test plan
- MULT a=0xFFFFFFFF, b=2 → stall_o high 2 cycles, then pulse with hilo_o={0xFFFFFFFF,0xFFFFFFFE}. MULTU with the same operands → {0x00000001,0xFFFFFFFE}.
- DIV a=-7 (0xFFFFFFF9), b=2 → stall_o high exactly 33 cycles, pulse in cycle 33, hilo_o={0xFFFFFFFF,0xFFFFFFFD}.
- DIVU a=100, b=7 → hilo_o={0x00000002,0x0000000E}. Immediately followed by MULTU 3×5 → second pulse 3 cycles after the first, hilo_o={0,15}.
- DIV a=0x12345678, b=0 → hilo_o={0x12345678,0xFFFFFFFF}, no exception, normal 33-cycle stall.
- DIV started, flush_i asserted in cycle 10 → stall_o low in cycle 10, IDLE in cycle 11, no result_valid_o, hilo_o keeps its prior value.
- rst asserted in cycle 20 of a DIV → IDLE, hilo_o=0, result_valid_o=0 next cycle. A new MULT then completes with normal 2-cycle latency.
